// File: rtl/warp_sched_ctrl.sv
// Warp scheduler control: pops ready warps from the warp table and issues them to fetch,
// and arbitrates table pushes between returning warps and wspawn requests.
module warp_sched_ctrl #(
  parameter int NUM_WARPS            = 8,
  parameter int LOG2_NUM_WARPS       = 3,
  parameter int MACHINE_WIDTH        = 64,
  parameter int NUM_THREADS_PER_WARP = 8,
  parameter int LINE_WIDTH           = LOG2_NUM_WARPS + MACHINE_WIDTH + NUM_THREADS_PER_WARP
) (
  input  logic                      clk,
  input  logic                      reset,
  // warp table pop side
  output logic                      tbl_read_en,
  input  logic [LINE_WIDTH-1:0]     tbl_read_data,
  input  logic                      tbl_empty,
  // warp table push side
  output logic                      tbl_write_en,
  output logic [LINE_WIDTH-1:0]     tbl_write_data,
  input  logic                      tbl_full,
  // returning warps from the pipeline
  input  logic                      ret_valid,
  output logic                      ret_ready,
  input  logic [LINE_WIDTH-1:0]     ret_data,
  input  logic                      ret_halt,
  // wspawn requests
  input  logic                      spawn_valid,
  output logic                      spawn_ready,
  input  logic [LOG2_NUM_WARPS-1:0] spawn_id,
  input  logic [MACHINE_WIDTH-1:0]  spawn_pc,
  // issue to fetch
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [LINE_WIDTH-1:0]     issue_data,
  // status
  output logic [NUM_WARPS-1:0]      warp_active,
  output logic                      spawn_err,
  output logic                      all_halted
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } issue_state_e;

  issue_state_e              state_q, state_d;
  logic                      issue_fresh_q;
  logic [LINE_WIDTH-1:0]     issue_hold_q;
  logic [NUM_WARPS-1:0]      warp_active_q, warp_active_d;
  logic                      spawn_err_q;
  logic                      all_halted_q;

  logic [LOG2_NUM_WARPS-1:0] ret_id;
  logic                      ret_fire, ret_push, ret_retire;
  logic                      spawn_fire, spawn_legal, spawn_push, spawn_reject;

  // ---------------------------------------------------------------------------
  // Issue FSM: IDLE pops the table head, ISSUE presents it until fetch takes it.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    state_d     = state_q;
    tbl_read_en = 1'b0;
    issue_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        tbl_read_en = !tbl_empty && !reset;
        if (tbl_read_en) state_d = ISSUE;
      end
      ISSUE: begin
        issue_valid = !reset;
        if (issue_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The table head is live on the first ISSUE cycle; later stall cycles replay the copy.
  always_comb begin
    issue_data = '0;
    if (state_q == ISSUE) issue_data = issue_fresh_q ? tbl_read_data : issue_hold_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q       <= IDLE;
      issue_fresh_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_fresh_q <= (state_q == IDLE) && (state_d == ISSUE);
    end
  end

  // NOTE: the hold register is pure datapath; issue_fresh_q/state_q qualify it, so it has no reset.
  always_ff @(posedge clk) begin
    if (issue_fresh_q) issue_hold_q <= tbl_read_data;
  end

  // ---------------------------------------------------------------------------
  // Write arbiter: one push per cycle, return path wins over spawn.
  // ---------------------------------------------------------------------------
  assign ret_id      = ret_data[LINE_WIDTH-1 -: LOG2_NUM_WARPS];

  assign ret_ready   = !reset && (ret_halt || !tbl_full);
  assign ret_fire    = ret_valid && ret_ready;
  assign ret_push    = ret_fire && !ret_halt;
  assign ret_retire  = ret_fire && ret_halt;

  // Spawn yields whenever a non-halting return wants the single push slot.
  assign spawn_ready = !reset && !tbl_full && !(ret_valid && !ret_halt);
  assign spawn_fire  = spawn_valid && spawn_ready;
  // Legality looks at the registered bitmap, before this cycle's halt clears.
  assign spawn_legal  = !warp_active_q[spawn_id];
  assign spawn_push   = spawn_fire && spawn_legal;
  assign spawn_reject = spawn_fire && !spawn_legal;

  assign tbl_write_en = ret_push || spawn_push;

  always_comb begin
    tbl_write_data = '0;
    if (ret_push)
      tbl_write_data = ret_data;
    else if (spawn_push)
      tbl_write_data = {spawn_id, spawn_pc, {NUM_THREADS_PER_WARP{1'b1}}};
  end

  always_comb begin
    warp_active_d = warp_active_q;
    if (ret_retire) warp_active_d[ret_id]   = 1'b0;
    if (spawn_push) warp_active_d[spawn_id] = 1'b1;
  end

  // After reset the table is preloaded with every warp, so all start live.
  always_ff @(posedge clk) begin
    if (reset) begin
      warp_active_q <= '1;
      spawn_err_q   <= 1'b0;
      all_halted_q  <= 1'b0;
    end else begin
      warp_active_q <= warp_active_d;
      spawn_err_q   <= spawn_reject;
      all_halted_q  <= (warp_active_q == '0) && (state_q == IDLE) && tbl_empty;
    end
  end

  assign warp_active = warp_active_q;
  assign spawn_err   = spawn_err_q;
  assign all_halted  = all_halted_q;

endmodule

// File: tb/tb_warp_sched_ctrl.sv
// Directed bench for warp_sched_ctrl: issue FSM, push arbitration, spawn legality, halting and reset.
module tb_warp_sched_ctrl;

  localparam int NW = 8;
  localparam int LW = 3 + 64 + 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          tbl_read_en;
  logic [LW-1:0] tbl_read_data;
  logic          tbl_empty;
  logic          tbl_write_en;
  logic [LW-1:0] tbl_write_data;
  logic          tbl_full;
  logic          ret_valid;
  logic          ret_ready;
  logic [LW-1:0] ret_data;
  logic          ret_halt;
  logic          spawn_valid;
  logic          spawn_ready;
  logic [2:0]    spawn_id;
  logic [63:0]   spawn_pc;
  logic          issue_valid;
  logic          issue_ready;
  logic [LW-1:0] issue_data;
  logic [NW-1:0] warp_active;
  logic          spawn_err;
  logic          all_halted;

  int n_checks = 0;
  int n_errors = 0;

  warp_sched_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .tbl_read_en    (tbl_read_en),
    .tbl_read_data  (tbl_read_data),
    .tbl_empty      (tbl_empty),
    .tbl_write_en   (tbl_write_en),
    .tbl_write_data (tbl_write_data),
    .tbl_full       (tbl_full),
    .ret_valid      (ret_valid),
    .ret_ready      (ret_ready),
    .ret_data       (ret_data),
    .ret_halt       (ret_halt),
    .spawn_valid    (spawn_valid),
    .spawn_ready    (spawn_ready),
    .spawn_id       (spawn_id),
    .spawn_pc       (spawn_pc),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_data     (issue_data),
    .warp_active    (warp_active),
    .spawn_err      (spawn_err),
    .all_halted     (all_halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pkt(input logic [2:0] id, input logic [63:0] pc,
                                        input logic [7:0] mask);
    return {id, pc, mask};
  endfunction

  // Advance to just after the next rising edge; drives placed after this are clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset         = 1'b1;
    tbl_read_data = '0;
    tbl_empty     = 1'b0;
    tbl_full      = 1'b0;
    ret_valid     = 1'b1;
    ret_halt      = 1'b1;
    ret_data      = pkt(3'd0, 64'd0, 8'hFF);
    spawn_valid   = 1'b1;
    spawn_id      = 3'd0;
    spawn_pc      = 64'd0;
    issue_ready   = 1'b1;

    // Reset: every handshake output suppressed even with requests pending.
    tick();
    mid();
    check("rst_read_en",   tbl_read_en, 0);
    check("rst_write_en",  tbl_write_en, 0);
    check("rst_issue_vld", issue_valid, 0);
    check("rst_ret_rdy",   ret_ready, 0);
    check("rst_spawn_rdy", spawn_ready, 0);
    tick();
    check("rst_active",    warp_active, 8'hFF);
    check("rst_spawn_err", spawn_err, 0);
    check("rst_halted",    all_halted, 0);

    // Release with a non-empty table: pop, issue, pop, ... every 2 cycles.
    ret_valid     = 1'b0;
    ret_halt      = 1'b0;
    spawn_valid   = 1'b0;
    tbl_read_data = pkt(3'd0, 64'd0, 8'hFF);
    reset         = 1'b0;
    mid();
    check("a_read_en0",   tbl_read_en, 1);
    check("a_issue_vld0", issue_valid, 0);
    tick();
    mid();
    check("a_issue_vld1", issue_valid, 1);
    check("a_issue_dat1", issue_data, pkt(3'd0, 64'd0, 8'hFF));
    check("a_read_en1",   tbl_read_en, 0);
    tick();
    mid();
    check("a_read_en2",   tbl_read_en, 1);
    check("a_issue_vld2", issue_valid, 0);

    // Stall for 5 cycles in ISSUE: packet held, no further pop.
    issue_ready   = 1'b0;
    tick();
    tbl_read_data = pkt(3'd1, 64'h8, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      mid();
      check("b_issue_vld", issue_valid, 1);
      check("b_issue_dat", issue_data, pkt(3'd1, 64'h8, 8'hFF));
      check("b_read_en",   tbl_read_en, 0);
      if (i < 4) tick();
    end
    issue_ready = 1'b1;
    tbl_empty   = 1'b1;
    tick();
    mid();
    check("b_idle_vld",  issue_valid, 0);
    check("b_idle_read", tbl_read_en, 0);

    // Halt warp 6 so a later spawn of it is legal.
    tick();
    ret_valid = 1'b1;
    ret_halt  = 1'b1;
    ret_data  = pkt(3'd6, 64'h0, 8'hFF);
    mid();
    check("h6_ret_rdy",  ret_ready, 1);
    check("h6_write_en", tbl_write_en, 0);
    tick();
    check("h6_active",   warp_active, 8'hBF);

    // Return and spawn together: return pushed first, spawn waits one cycle.
    ret_halt    = 1'b0;
    ret_data    = pkt(3'd3, 64'h40, 8'hFF);
    spawn_valid = 1'b1;
    spawn_id    = 3'd6;
    spawn_pc    = 64'h200;
    mid();
    check("c_ret_rdy",    ret_ready, 1);
    check("c_spawn_rdy",  spawn_ready, 0);
    check("c_write_en",   tbl_write_en, 1);
    check("c_write_dat",  tbl_write_data, pkt(3'd3, 64'h40, 8'hFF));
    tick();
    ret_valid = 1'b0;
    mid();
    check("c_spawn_rdy2", spawn_ready, 1);
    check("c_write_en2",  tbl_write_en, 1);
    check("c_write_dat2", tbl_write_data, pkt(3'd6, 64'h200, 8'hFF));
    tick();
    spawn_valid = 1'b0;
    check("c_active",     warp_active, 8'hFF);
    check("c_spawn_err",  spawn_err, 0);

    // Halt warp 5, respawn it, then spawn it again while live.
    ret_valid = 1'b1;
    ret_halt  = 1'b1;
    ret_data  = pkt(3'd5, 64'h0, 8'hFF);
    mid();
    check("d_halt_wen",   tbl_write_en, 0);
    tick();
    ret_valid = 1'b0;
    check("d_active0",    warp_active, 8'hDF);
    spawn_valid = 1'b1;
    spawn_id    = 3'd5;
    spawn_pc    = 64'h100;
    mid();
    check("d_spawn_wen",  tbl_write_en, 1);
    check("d_spawn_dat",  tbl_write_data, pkt(3'd5, 64'h100, 8'hFF));
    tick();
    check("d_active1",    warp_active, 8'hFF);
    check("d_err0",       spawn_err, 0);
    mid();
    check("d_dup_rdy",    spawn_ready, 1);
    check("d_dup_wen",    tbl_write_en, 0);
    tick();
    spawn_valid = 1'b0;
    check("d_err1",       spawn_err, 1);
    check("d_active2",    warp_active, 8'hFF);
    tick();
    check("d_err_clr",    spawn_err, 0);

    // Same-cycle halt X + spawn X: spawn rejected, X ends inactive.
    ret_valid   = 1'b1;
    ret_halt    = 1'b1;
    ret_data    = pkt(3'd2, 64'h0, 8'hFF);
    spawn_valid = 1'b1;
    spawn_id    = 3'd2;
    spawn_pc    = 64'h300;
    mid();
    check("e_xx_wen",     tbl_write_en, 0);
    tick();
    check("e_xx_err",     spawn_err, 1);
    check("e_xx_active",  warp_active, 8'hFB);

    // Same-cycle halt 4 + spawn 2: both complete.
    ret_data = pkt(3'd4, 64'h0, 8'hFF);
    mid();
    check("e_xy_wen",     tbl_write_en, 1);
    check("e_xy_dat",     tbl_write_data, pkt(3'd2, 64'h300, 8'hFF));
    tick();
    check("e_xy_err",     spawn_err, 0);
    check("e_xy_active",  warp_active, 8'hEF);

    // Table full: only halting returns get through, nothing is pushed.
    tbl_full    = 1'b1;
    ret_halt    = 1'b0;
    ret_data    = pkt(3'd1, 64'h80, 8'hFF);
    spawn_id    = 3'd4;
    mid();
    check("f_ret_rdy",    ret_ready, 0);
    check("f_spawn_rdy",  spawn_ready, 0);
    check("f_write_en",   tbl_write_en, 0);
    tick();
    ret_halt    = 1'b1;
    spawn_valid = 1'b0;
    mid();
    check("f_halt_rdy",   ret_ready, 1);
    check("f_halt_wen",   tbl_write_en, 0);
    tick();
    check("f_active",     warp_active, 8'hED);
    tbl_full = 1'b0;

    // Halt every warp with the table drained.
    for (int i = 0; i < NW; i++) begin
      ret_data = pkt(3'(i), 64'h0, 8'hFF);
      tick();
    end
    ret_valid = 1'b0;
    ret_halt  = 1'b0;
    check("g_active0",    warp_active, 8'h00);
    tick();
    check("g_halted",     all_halted, 1);

    // Reset while a packet sits in ISSUE: it is dropped, all warps revive.
    tbl_empty     = 1'b0;
    issue_ready   = 1'b0;
    tbl_read_data = pkt(3'd7, 64'h500, 8'hFF);
    tick();
    mid();
    check("g_in_issue",   issue_valid, 1);
    tick();
    reset = 1'b1;
    mid();
    check("g_rst_vld",    issue_valid, 0);
    tick();
    reset = 1'b0;
    tbl_empty = 1'b1;
    check("g_rst_active", warp_active, 8'hFF);
    check("g_rst_halted", all_halted, 0);
    mid();
    check("g_post_vld",   issue_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/warp_sched_ctrl.md
WARP_SCHED_CTRL -- requirements
Module: warp_sched_ctrl

Interface
REQ-001 SHALL have parameters: NUM_WARPS, default 8, number of hardware warps; LOG2_NUM_WARPS, default 3, warp ID width; MACHINE_WIDTH, default 64, PC width; NUM_THREADS_PER_WARP, default 8, mask width; LINE_WIDTH, default LOG2_NUM_WARPS+MACHINE_WIDTH+NUM_THREADS_PER_WARP, packet width {id, pc, mask}, id in MSBs.
REQ-002 SHALL have ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
tbl_read_en  out  1  pop request to warp table
tbl_read_data  in  LINE_WIDTH  warp table head packet, valid the cycle after tbl_read_en
tbl_empty  in  1  warp table empty
tbl_write_en  out  1  push request to warp table
tbl_write_data  out  LINE_WIDTH  packet pushed
tbl_full  in  1  warp table full
ret_valid / ret_ready  in / out  1 / 1  returning-warp handshake from pipeline
ret_data  in  LINE_WIDTH  returning warp {id, next pc, mask}
ret_halt  in  1  returning warp has executed halt
spawn_valid / spawn_ready  in / out  1 / 1  wspawn request handshake
spawn_id  in  LOG2_NUM_WARPS  warp to spawn
spawn_pc  in  MACHINE_WIDTH  start PC of spawned warp
issue_valid / issue_ready  out / in  1 / 1  warp issue handshake to fetch
issue_data  out  LINE_WIDTH  issued warp packet
warp_active  out  NUM_WARPS  per-warp live bitmap
spawn_err  out  1  one-cycle pulse: spawn of an active warp
all_halted  out  1  no live warps, nothing in flight

Function
REQ-003 Issue FSM SHALL have two states: IDLE, ISSUE.
REQ-004 In IDLE, tbl_read_en SHALL equal !tbl_empty (combinational); if asserted, next state ISSUE, else stay IDLE.
REQ-005 In ISSUE, issue_valid SHALL be 1 and issue_data SHALL equal tbl_read_data; tbl_read_en SHALL be 0.
REQ-006 In ISSUE with issue_ready=1, next state SHALL be IDLE; with issue_ready=0, stay ISSUE with issue_data stable.
REQ-007 Latency: tbl_read_en in cycle N -> issue_valid in cycle N+1; max throughput one issue per 2 cycles.
REQ-008 issue_valid and tbl_read_en SHALL be 0 in IDLE and ISSUE respectively; never both 1.
REQ-009 Write arbiter SHALL grant at most one table push per cycle; return path has fixed priority over spawn.
REQ-010 ret_ready SHALL equal ret_halt | !tbl_full (combinational).
REQ-011 Return accepted with ret_halt=0 SHALL assert tbl_write_en with tbl_write_data=ret_data, same cycle.
REQ-012 Return accepted with ret_halt=1 SHALL NOT push; warp_active[ret_data id] SHALL clear next cycle.
REQ-013 spawn_ready SHALL equal !tbl_full & !(ret_valid & !ret_halt).
REQ-014 Spawn accepted with warp_active[spawn_id]=0 SHALL push {spawn_id, spawn_pc, all-ones mask} and set warp_active[spawn_id] next cycle.
REQ-015 Spawn accepted with warp_active[spawn_id]=1 SHALL NOT push, SHALL leave warp_active unchanged, SHALL pulse spawn_err for exactly the next cycle.
REQ-016 Spawn legality SHALL be checked against warp_active before this cycle's updates; same-cycle halt of X plus spawn of X -> spawn_err, X ends inactive.
REQ-017 Same-cycle halt of X and spawn of Y (X!=Y) SHALL both complete: X cleared, Y set and pushed.
REQ-018 tbl_write_en SHALL be 0 whenever tbl_full=1; no push is ever dropped once handshake completes.
REQ-019 all_halted SHALL be registered: 1 when warp_active==0, FSM in IDLE, tbl_empty=1.
REQ-020 Issue and write paths SHALL operate independently in the same cycle.

Reset
REQ-021 On reset=1 at a rising edge: FSM -> IDLE, warp_active -> all ones (matches warp table preload of warps 0..NUM_WARPS-1), spawn_err -> 0, all_halted -> 0.
REQ-022 During reset cycle and while reset=1: tbl_read_en, tbl_write_en, issue_valid, ret_ready, spawn_ready SHALL be 0; a packet held in ISSUE is discarded.

Verification
REQ-023 After reset, tbl_empty=0, issue_ready=1 -> tbl_read_en 1 cycle after reset release, issue_valid next cycle with table head (id 0, pc 0, mask 8'hFF); pattern repeats every 2 cycles.
REQ-024 issue_ready=0 for 5 cycles in ISSUE -> issue_valid held, issue_data stable, tbl_read_en 0 throughout; no pop lost.
REQ-025 ret_valid(id 3, pc 0x40, halt=0) and spawn_valid same cycle, tbl_full=0 -> return pushed, spawn_ready=0; spawn pushed next cycle.
REQ-026 ret_valid halt=1 id 5, then spawn id 5 pc 0x100 -> warp_active[5] 1->0->1, push {5, 0x100, 8'hFF}, spawn_err 0; repeat spawn id 5 -> spawn_err 1-cycle pulse, no push.
REQ-027 tbl_full=1 -> ret_ready=0 (halt=0), spawn_ready=0, tbl_write_en=0; ret with halt=1 still accepted.
REQ-028 Halt all 8 warps with table drained -> warp_active=0, all_halted=1; reset asserted while in ISSUE -> issue_valid 0 next cycle, warp_active=8'hFF.
